// File: rtl/fir_mac.sv
// fir_mac: stereo FIR multiply-accumulate engine driven by an external
// coefficient ROM. One left/right sample pair arrives per cycle while
// `sequencing` is high. Each pair is multiplied by the matching coefficient
// and accumulated over NTAPS taps. The sum is shifted right by FRAC,
// clamped to DATA_W bits and loaded into the output registers.
//
// Ports
//   clk, rst_n               clock; synchronous active-low reset
//   sequencing               high while a run of sample pairs is presented
//   lft_in, rht_in           signed left/right samples
//   coef_addr                registered coefficient ROM address
//   coef                     signed ROM data, one cycle behind coef_addr
//   filtered_L, filtered_R   registered signed results
//   valid                    one-cycle pulse when results load
//   sat                      high if either channel clipped (with results)
//   abort                    one-cycle pulse when a run is cancelled
`timescale 1ns/1ps

module fir_mac #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned NTAPS  = 1021,
    parameter int unsigned FRAC   = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sequencing,
    input  logic signed [DATA_W-1:0] lft_in,
    input  logic signed [DATA_W-1:0] rht_in,
    output logic        [9:0]        coef_addr,
    input  logic signed [COEF_W-1:0] coef,
    output logic signed [DATA_W-1:0] filtered_L,
    output logic signed [DATA_W-1:0] filtered_R,
    output logic                     valid,
    output logic                     sat,
    output logic                     abort
);

    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam int unsigned ACC_W  = PROD_W + 10;
    localparam int unsigned CNT_W  = 10;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NTAPS - 1);

    // Clamp limits expressed at accumulator width for signed comparison
    localparam logic signed [ACC_W-1:0] C_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] C_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    logic        [CNT_W-1:0]   r_coef_addr;
    logic        [CNT_W-1:0]   r_tap;
    logic signed [DATA_W-1:0]  r_smp_l;
    logic signed [DATA_W-1:0]  r_smp_r;
    logic signed [ACC_W-1:0]   r_acc_l;
    logic signed [ACC_W-1:0]   r_acc_r;
    logic signed [DATA_W-1:0]  r_filt_l;
    logic signed [DATA_W-1:0]  r_filt_r;
    logic                      r_valid;
    logic                      r_sat;
    logic                      r_abort;

    logic signed [PROD_W-1:0]  w_prod_l;
    logic signed [PROD_W-1:0]  w_prod_r;
    logic signed [ACC_W-1:0]   w_acc_l;
    logic signed [ACC_W-1:0]   w_acc_r;
    logic signed [ACC_W-1:0]   w_shift_l;
    logic signed [ACC_W-1:0]   w_shift_r;
    logic                      w_hi_l;
    logic                      w_lo_l;
    logic                      w_hi_r;
    logic                      w_lo_r;
    logic signed [DATA_W-1:0]  w_res_l;
    logic signed [DATA_W-1:0]  w_res_r;

    // Full-precision products and the accumulator value after this tap
    assign w_prod_l = r_smp_l * coef;
    assign w_prod_r = r_smp_r * coef;
    assign w_acc_l  = r_acc_l + ACC_W'(w_prod_l);
    assign w_acc_r  = r_acc_r + ACC_W'(w_prod_r);

    // Final scaling (floor shift) and clamp; used only on the last tap so the
    // result lands on the same edge as the final MAC
    assign w_shift_l = w_acc_l >>> FRAC;
    assign w_shift_r = w_acc_r >>> FRAC;
    assign w_hi_l    = w_shift_l > C_MAX;
    assign w_lo_l    = w_shift_l < C_MIN;
    assign w_hi_r    = w_shift_r > C_MAX;
    assign w_lo_r    = w_shift_r < C_MIN;
    assign w_res_l   = w_hi_l ? {1'b0, {(DATA_W-1){1'b1}}} :
                       w_lo_l ? {1'b1, {(DATA_W-1){1'b0}}} : w_shift_l[DATA_W-1:0];
    assign w_res_r   = w_hi_r ? {1'b0, {(DATA_W-1){1'b1}}} :
                       w_lo_r ? {1'b1, {(DATA_W-1){1'b0}}} : w_shift_r[DATA_W-1:0];

    // Control FSM, sample delay stage, accumulators and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_coef_addr <= '0;
            r_tap       <= '0;
            r_smp_l     <= '0;
            r_smp_r     <= '0;
            r_acc_l     <= '0;
            r_acc_r     <= '0;
            r_filt_l    <= '0;
            r_filt_r    <= '0;
            r_valid     <= 1'b0;
            r_sat       <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            // Sample k is delayed one cycle so it meets coef[k] from the ROM
            r_smp_l <= lft_in;
            r_smp_r <= rht_in;
            r_valid <= 1'b0;
            r_abort <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_acc_l <= '0;
                    r_acc_r <= '0;
                    r_tap   <= '0;
                    if (sequencing) begin
                        r_state     <= S_RUN;
                        r_coef_addr <= CNT_W'(1);
                    end else begin
                        r_coef_addr <= '0;
                    end
                end

                S_RUN: begin
                    // r_tap < LAST means the sample of this cycle is still needed
                    if (!sequencing && (r_tap < LAST)) begin
                        r_state     <= S_IDLE;
                        r_abort     <= 1'b1;
                        r_coef_addr <= '0;
                        r_tap       <= '0;
                        r_acc_l     <= '0;
                        r_acc_r     <= '0;
                    end else if (r_tap == LAST) begin
                        r_state     <= S_DONE;
                        r_filt_l    <= w_res_l;
                        r_filt_r    <= w_res_r;
                        r_sat       <= w_hi_l | w_lo_l | w_hi_r | w_lo_r;
                        r_valid     <= 1'b1;
                        r_coef_addr <= '0;
                        r_tap       <= '0;
                        r_acc_l     <= '0;
                        r_acc_r     <= '0;
                    end else begin
                        r_acc_l     <= w_acc_l;
                        r_acc_r     <= w_acc_r;
                        r_tap       <= r_tap + CNT_W'(1);
                        r_coef_addr <= (r_coef_addr == LAST) ? LAST : r_coef_addr + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    r_coef_addr <= '0;
                    r_tap       <= '0;
                    r_acc_l     <= '0;
                    r_acc_r     <= '0;
                    if (!sequencing) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_coef_addr <= '0;
                    r_tap       <= '0;
                    r_acc_l     <= '0;
                    r_acc_r     <= '0;
                end
            endcase
        end
    end

    assign coef_addr  = r_coef_addr;
    assign filtered_L = r_filt_l;
    assign filtered_R = r_filt_r;
    assign valid      = r_valid;
    assign sat        = r_sat;
    assign abort      = r_abort;

endmodule

// File: tb/tb_fir_mac.sv
// tb_fir_mac: self-checking bench for fir_mac. Three instances are used:
// A (NTAPS=4, FRAC=0), B (NTAPS=4, FRAC=15) and C (defaults, 1021 taps).
// A and B share stimulus. Expected results come from a plain dot-product
// reference over the ROM contents and the samples of each run.
`timescale 1ns/1ps

module tb_fir_mac;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        seq_ab;
    logic        seq_c;
    logic [15:0] lft;
    logic [15:0] rht;

    logic [9:0]  addr_a, addr_b, addr_c;
    logic [15:0] coef_a, coef_b, coef_c;
    logic [15:0] fl_a, fr_a, fl_b, fr_b, fl_c, fr_c;
    logic        v_a, s_a, ab_a, v_b, s_b, ab_b, v_c, s_c, ab_c;

    logic signed [15:0] rom_ab [0:1023];
    logic signed [15:0] rom_c  [0:1023];
    logic signed [15:0] smp_l  [0:1023];
    logic signed [15:0] smp_r  [0:1023];

    // Registered ROMs: data is one cycle behind the address
    always @(posedge clk) begin
        coef_a <= rom_ab[addr_a];
        coef_b <= rom_ab[addr_b];
        coef_c <= rom_c[addr_c];
    end

    fir_mac #(.DATA_W(16), .COEF_W(16), .NTAPS(4), .FRAC(0)) u_a (
        .clk(clk), .rst_n(rst_n), .sequencing(seq_ab), .lft_in(lft), .rht_in(rht),
        .coef_addr(addr_a), .coef(coef_a), .filtered_L(fl_a), .filtered_R(fr_a),
        .valid(v_a), .sat(s_a), .abort(ab_a));

    fir_mac #(.DATA_W(16), .COEF_W(16), .NTAPS(4), .FRAC(15)) u_b (
        .clk(clk), .rst_n(rst_n), .sequencing(seq_ab), .lft_in(lft), .rht_in(rht),
        .coef_addr(addr_b), .coef(coef_b), .filtered_L(fl_b), .filtered_R(fr_b),
        .valid(v_b), .sat(s_b), .abort(ab_b));

    fir_mac u_c (
        .clk(clk), .rst_n(rst_n), .sequencing(seq_c), .lft_in(lft), .rht_in(rht),
        .coef_addr(addr_c), .coef(coef_c), .filtered_L(fl_c), .filtered_R(fr_c),
        .valid(v_c), .sat(s_c), .abort(ab_c));

    int checks   = 0;
    int failures = 0;

    logic [15:0] ex_l_a, ex_r_a, ex_l_b, ex_r_b;
    logic        ex_s_a, ex_s_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Floor shift then clamp to 16 bits; bit 16 flags clipping
    function automatic logic [16:0] sat16(input longint a, input int frac);
        longint v;
        v = a >>> frac;
        if (v > 64'sd32767)       return {1'b1, 16'h7fff};
        else if (v < -64'sd32768) return {1'b1, 16'h8000};
        return {1'b0, v[15:0]};
    endfunction

    task automatic model(input int nt, input int frac, input bit use_c,
                         output logic [15:0] rl, output logic [15:0] rr, output logic s);
        longint al, ar, cf;
        logic [16:0] ql, qr;
        al = 0;
        ar = 0;
        for (int k = 0; k < nt; k++) begin
            cf = use_c ? longint'(rom_c[k]) : longint'(rom_ab[k]);
            al += cf * longint'(smp_l[k]);
            ar += cf * longint'(smp_r[k]);
        end
        ql = sat16(al, frac);
        qr = sat16(ar, frac);
        rl = ql[15:0];
        rr = qr[15:0];
        s  = ql[16] | qr[16];
    endtask

    // One A/B run: sequencing high for `hold` cycles starting at T0 (c=0)
    task automatic run_ab(input int hold);
        int          nt;
        int          last;
        int          exp_addr;
        bit          full;
        logic [15:0] nl_a, nr_a, nl_b, nr_b;
        logic        ns_a, ns_b;
        nt   = 4;
        full = (hold >= nt);
        last = (hold > nt + 1) ? hold : nt + 1;
        model(nt, 0,  1'b0, nl_a, nr_a, ns_a);
        model(nt, 15, 1'b0, nl_b, nr_b, ns_b);
        for (int c = 0; c <= last; c++) begin
            seq_ab = (c < hold);
            lft    = (c < nt) ? smp_l[c] : 16'($urandom);
            rht    = (c < nt) ? smp_r[c] : 16'($urandom);
            if (full && c == nt + 1) begin
                ex_l_a = nl_a; ex_r_a = nr_a; ex_s_a = ns_a;
                ex_l_b = nl_b; ex_r_b = nr_b; ex_s_b = ns_b;
            end
            if (full) exp_addr = (c < nt) ? c : ((c == nt) ? nt - 1 : 0);
            else      exp_addr = (c <= hold) ? c : 0;
            chk("addr_a",  32'(addr_a), 32'(exp_addr));
            chk("addr_b",  32'(addr_b), 32'(exp_addr));
            chk("valid_a", 32'(v_a),    32'(full && c == nt + 1));
            chk("valid_b", 32'(v_b),    32'(full && c == nt + 1));
            chk("abort_a", 32'(ab_a),   32'(!full && c == hold + 1));
            chk("abort_b", 32'(ab_b),   32'(!full && c == hold + 1));
            chk("fl_a",    32'(fl_a),   32'(ex_l_a));
            chk("fr_a",    32'(fr_a),   32'(ex_r_a));
            chk("sat_a",   32'(s_a),    32'(ex_s_a));
            chk("fl_b",    32'(fl_b),   32'(ex_l_b));
            chk("fr_b",    32'(fr_b),   32'(ex_r_b));
            chk("sat_b",   32'(s_b),    32'(ex_s_b));
            step();
        end
    endtask

    // One full run on the default-size instance
    task automatic run_c();
        int          nt;
        int          exp_addr;
        logic [15:0] nl, nr;
        logic        ns;
        nt = 1021;
        model(nt, 15, 1'b1, nl, nr, ns);
        for (int c = 0; c <= nt + 1; c++) begin
            seq_c    = (c < nt);
            lft      = (c < nt) ? smp_l[c] : 16'($urandom);
            rht      = (c < nt) ? smp_r[c] : 16'($urandom);
            exp_addr = (c < nt) ? c : ((c == nt) ? nt - 1 : 0);
            chk("addr_c",  32'(addr_c), 32'(exp_addr));
            chk("valid_c", 32'(v_c),    32'(c == nt + 1));
            chk("abort_c", 32'(ab_c),   32'(0));
            if (c == nt + 1) begin
                chk("fl_c",  32'(fl_c), 32'(nl));
                chk("fr_c",  32'(fr_c), 32'(nr));
                chk("sat_c", 32'(s_c),  32'(ns));
            end
            step();
        end
    endtask

    task automatic load_golden();
        rom_ab[0] = 16'sd1; rom_ab[1] = 16'sd2; rom_ab[2] = 16'sd3; rom_ab[3] = 16'sd4;
        for (int k = 0; k < 4; k++) begin
            smp_l[k] = 16'sd1;
            smp_r[k] = (k == 0) ? 16'sd2 : 16'sd0;
        end
    endtask

    task automatic load_random_ab();
        for (int k = 0; k < 4; k++) begin
            rom_ab[k] = 16'($urandom);
            smp_l[k]  = 16'($urandom);
            smp_r[k]  = 16'($urandom);
        end
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) begin
            rom_ab[k] = '0; rom_c[k] = '0; smp_l[k] = '0; smp_r[k] = '0;
        end
        ex_l_a = '0; ex_r_a = '0; ex_s_a = 1'b0;
        ex_l_b = '0; ex_r_b = '0; ex_s_b = 1'b0;
        rst_n  = 1'b0;
        seq_ab = 1'b0;
        seq_c  = 1'b0;
        lft    = '0;
        rht    = '0;
        repeat (3) step();

        // Reset state
        chk("rst_addr_a",  32'(addr_a), 32'(0));
        chk("rst_fl_a",    32'(fl_a),   32'(0));
        chk("rst_fr_a",    32'(fr_a),   32'(0));
        chk("rst_valid_a", 32'(v_a),    32'(0));
        chk("rst_sat_a",   32'(s_a),    32'(0));
        chk("rst_abort_a", 32'(ab_a),   32'(0));
        chk("rst_addr_c",  32'(addr_c), 32'(0));
        chk("rst_fl_c",    32'(fl_c),   32'(0));
        chk("rst_valid_c", 32'(v_c),    32'(0));
        rst_n = 1'b1;
        step();

        // Golden small-kernel run
        load_golden();
        run_ab(4);
        chk("gold_fl_a",  32'(fl_a), 32'(10));
        chk("gold_fr_a",  32'(fr_a), 32'(2));
        chk("gold_sat_a", 32'(s_a),  32'(0));

        // Saturation in both directions
        for (int k = 0; k < 4; k++) begin
            rom_ab[k] = 16'sh7fff; smp_l[k] = 16'sh7fff; smp_r[k] = 16'sh8000;
        end
        run_ab(4);
        chk("satr_fl_b", 32'(fl_b), 32'h7fff);
        chk("satr_fr_b", 32'(fr_b), 32'h8000);
        chk("satr_s_b",  32'(s_b),  32'(1));

        // Aborts at every needed-sample position, outputs must hold
        load_random_ab(); run_ab(2);
        load_random_ab(); run_ab(1);
        load_random_ab(); run_ab(3);

        // Long sequencing hold, then a second golden run after one low cycle
        load_golden();
        run_ab(10);
        run_ab(4);
        chk("gold2_fl_a", 32'(fl_a), 32'(10));
        chk("gold2_fr_a", 32'(fr_a), 32'(2));

        // Randomized runs, some aborting, some saturating
        for (int r = 0; r < 8; r++) begin
            load_random_ab();
            run_ab(int'($urandom_range(1, 8)));
        end

        // Reset in the middle of a run (outputs nonzero beforehand)
        load_golden();
        run_ab(4);
        seq_ab = 1'b1; lft = 16'($urandom); rht = 16'($urandom);
        step();
        lft = 16'($urandom); rht = 16'($urandom);
        step();
        rst_n = 1'b0;
        step();
        chk("mrst_addr_a",  32'(addr_a), 32'(0));
        chk("mrst_fl_a",    32'(fl_a),   32'(0));
        chk("mrst_fr_a",    32'(fr_a),   32'(0));
        chk("mrst_sat_a",   32'(s_a),    32'(0));
        chk("mrst_valid_a", 32'(v_a),    32'(0));
        chk("mrst_abort_a", 32'(ab_a),   32'(0));
        chk("mrst_abort_b", 32'(ab_b),   32'(0));
        ex_l_a = '0; ex_r_a = '0; ex_s_a = 1'b0;
        ex_l_b = '0; ex_r_b = '0; ex_s_b = 1'b0;
        rst_n = 1'b1;
        load_random_ab();
        run_ab(4);

        // Default 1021-tap runs: moderate coefficients, then full range
        for (int k = 0; k < 1021; k++) begin
            rom_c[k] = 16'(int'($urandom_range(0, 4095)) - 2048);
            smp_l[k] = 16'($urandom);
            smp_r[k] = 16'($urandom);
        end
        run_c();
        for (int k = 0; k < 1021; k++) begin
            rom_c[k] = 16'($urandom);
            smp_l[k] = 16'($urandom);
            smp_r[k] = 16'($urandom);
        end
        run_c();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_mac.md
FIR_MAC -- requirements
Module: fir_mac

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning signed sample and output width.
REQ-002 SHALL have parameter COEF_W, default 16, meaning signed coefficient width.
REQ-003 SHALL have parameter NTAPS, default 1021, meaning taps per run (legal range 2..1024).
REQ-004 SHALL have parameter FRAC, default 15, meaning accumulator right-shift applied before output.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-007 SHALL have port sequencing  input  1  high while one sample pair per cycle is presented.
REQ-008 SHALL have ports lft_in / rht_in  input  DATA_W each  signed left/right samples.
REQ-009 SHALL have port coef_addr  output  10  registered coefficient ROM address.
REQ-010 SHALL have port coef  input  COEF_W  signed ROM data, valid one cycle after coef_addr.
REQ-011 SHALL have ports filtered_L / filtered_R  output  DATA_W each  registered signed results.
REQ-012 SHALL have port valid  output  1  one-cycle pulse when new results load.
REQ-013 SHALL have port sat  output  1  registered with results; high if either channel clipped.
REQ-014 SHALL have port abort  output  1  one-cycle pulse when a run is cancelled.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE.
REQ-016 IDLE: coef_addr held 0, accumulators cleared; sequencing=1 -> RUN, coef_addr increments to 1 at that edge.
REQ-017 SHALL register lft_in/rht_in one stage so sample k meets coef[k]; cycle T0 = first sequencing-high cycle in IDLE.
REQ-018 RUN: at edge ending cycle T0+1+k, acc_L += coef*smp_L_d, acc_R += coef*smp_R_d, for k = 0..NTAPS-1.
REQ-019 coef_addr SHALL increment each RUN cycle and saturate at NTAPS-1 (no wrap, no modulo).
REQ-020 Products SHALL be full DATA_W+COEF_W signed; accumulators SHALL be DATA_W+COEF_W+10 bits, no overflow possible.
REQ-021 Result per channel = acc arithmetically shifted right by FRAC (truncation toward minus infinity), then clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-022 After the NTAPS-th MAC, the next edge SHALL load filtered_L/R and sat, pulse valid, enter DONE; valid is high during cycle T0+NTAPS+1.
REQ-023 filtered_L/R and sat SHALL hold between valid pulses.
REQ-024 DONE: coef_addr and accumulators cleared; stays while sequencing=1 (extra samples ignored); sequencing=0 -> IDLE.
REQ-025 sequencing=0 in RUN before the last needed sample is sampled SHALL pulse abort, enter IDLE, leave outputs unchanged, no valid.
REQ-026 Needed samples are cycles T0..T0+NTAPS-1; sequencing value in cycle T0+NTAPS is don't-care.
REQ-027 valid and abort SHALL never be high together.

Reset
REQ-028 rst_n=0 at an edge SHALL force IDLE, coef_addr=0, accumulators=0, sample regs=0, filtered_L/R=0, valid=0, sat=0, abort=0, regardless of state.
REQ-029 Reset mid-RUN SHALL discard the run with no valid or abort pulse; first cycle with rst_n=1 and sequencing=1 starts a new run.

Verification
REQ-030 NTAPS=4, FRAC=0, coefs {1,2,3,4}, lft 1,1,1,1, rht 2,0,0,0 -> valid at T0+5, filtered_L=10, filtered_R=2, sat=0.
REQ-031 NTAPS=4, FRAC=15, coefs all 0x7FFF, lft all 0x7FFF, rht all 0x8000 -> filtered_L=0x7FFF, filtered_R=0x8000, sat=1.
REQ-032 NTAPS=4, sequencing drops at T0+2 -> abort pulse at T0+3, no valid, prior outputs unchanged, coef_addr=0 next cycle.
REQ-033 NTAPS=4, sequencing held high 10 cycles -> exactly one valid; coef_addr sequence 0,1,2,3,3 then 0; second run after one low cycle matches golden.
REQ-034 Assert rst_n=0 at T0+2 of a run -> all outputs 0 next cycle, no valid/abort; NTAPS=1021 default random run matches reference model bit-exact.
